// File: rtl/patseq_pkg.sv
// Shared widths and state type for the pattern sequencer.
// Optional buffer chaining is enabled with PATSEQ_CHAIN_EN.
package patseq_pkg;
  localparam int BUFFER_SIZE  = 22;
  localparam int BUFFER_WIDTH = 8;
  localparam int NO_BUFS      = 8;
  localparam int BW           = $clog2(NO_BUFS);
  localparam int FW           = $clog2(BUFFER_SIZE);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/pattern_sequencer_if.sv
// Core-side control, write-request and playback stream bundle.
// The sequencer takes the slave side; the core control takes master.
interface pattern_sequencer_if;
  import patseq_pkg::*;

  logic                    start;
  logic                    stop;
  logic [BW-1:0]           start_buf;
  logic [FW-1:0]           len;
  logic                    loop_en;
  logic                    wr_req;
  logic [BW-1:0]           wr_buf;
  logic [FW-1:0]           wr_field;
  logic [BUFFER_WIDTH-1:0] wr_data;
  logic                    wr_ack;
  logic                    wr_err;
  logic                    out_valid;
  logic [BUFFER_WIDTH-1:0] out_byte;
  logic [FW-1:0]           out_field;
  logic                    busy;
  logic                    done;

  modport master (
    output start, stop, start_buf, len, loop_en,
    output wr_req, wr_buf, wr_field, wr_data,
    input  wr_ack, wr_err, out_valid, out_byte,
    input  out_field, busy, done
  );

  modport slave (
    input  start, stop, start_buf, len, loop_en,
    input  wr_req, wr_buf, wr_field, wr_data,
    output wr_ack, wr_err, out_valid, out_byte,
    output out_field, busy, done
  );
endinterface

// File: rtl/onehot_dec.sv
// Index to one-hot decoder; en low or an index past N gives all zeros.
module onehot_dec #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [IW-1:0] idx,
  input  logic          en,
  output logic [N-1:0]  oh
);
  always_comb begin
    oh = '0;
    for (int i = 0; i < N; i++)
      if (en && idx == IW'(i))
        oh[i] = 1'b1;
  end
endmodule

// File: rtl/pattern_sequencer.sv
// Pattern buffer playback sequencer with read/write slot arbitration.
// Define PATSEQ_CHAIN_EN to add chain_en (advance through all buffers).
module pattern_sequencer
  import patseq_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
`ifdef PATSEQ_CHAIN_EN
  input  logic                    chain_en,
`endif
  pattern_sequencer_if.slave      core,
  input  logic [BUFFER_WIDTH-1:0] field_byte,
  output logic [BW-1:0]           bufp,
  output logic [NO_BUFS-1:0]      buffer_select,
  output logic [BUFFER_SIZE-1:0]  fieldp,
  output logic [BUFFER_SIZE-1:0]  fieldwp,
  output logic [BUFFER_WIDTH-1:0] field_in,
  output logic                    field_write
);
  state_e                  state, state_n;
  logic [BW-1:0]           cur_buf, buf_n;
  logic [FW-1:0]           f, f_n;
  logic [FW-1:0]           last, last_n;
  logic [FW-1:0]           len_last;
  logic [FW-1:0]           wfield;
  logic                    done_n;
  logic                    rd_slot;
  logic                    grant;
  logic                    in_range;
  logic                    ack_q;
  logic                    err_q;
  logic                    valid_q;
  logic                    done_q;
  logic [BUFFER_WIDTH-1:0] byte_q;
  logic [FW-1:0]           ofield_q;
`ifdef PATSEQ_CHAIN_EN
  logic [BW-1:0]           first_buf, first_n;
  logic [BW-1:0]           nxt_buf;
`endif

  always_comb begin
    if (core.len == '0 || core.len > FW'(BUFFER_SIZE))
      len_last = FW'(BUFFER_SIZE - 1);
    else
      len_last = core.len - FW'(1);
  end

  // A write slot in RUN forces the following slot to be a read
  assign rd_slot  = (state == RUN) && !ack_q;
  assign grant    = core.wr_req && !((state == RUN) && ack_q);
  assign in_range = core.wr_field < FW'(BUFFER_SIZE);
`ifdef PATSEQ_CHAIN_EN
  assign nxt_buf  = cur_buf + BW'(1);
`endif

  always_comb begin
    state_n = state;
    buf_n   = cur_buf;
    f_n     = f;
    last_n  = last;
    done_n  = 1'b0;
`ifdef PATSEQ_CHAIN_EN
    first_n = first_buf;
`endif
    if (state == IDLE) begin
      if (core.start) begin
        state_n = RUN;
        buf_n   = core.start_buf;
        f_n     = '0;
        last_n  = len_last;
`ifdef PATSEQ_CHAIN_EN
        first_n = core.start_buf;
`endif
      end
    end else if (core.stop) begin
      state_n = IDLE;
    end else if (rd_slot) begin
      if (f != last) begin
        f_n = f + FW'(1);
      end else if (core.loop_en) begin
        f_n = '0;
`ifdef PATSEQ_CHAIN_EN
      end else if (chain_en && nxt_buf != first_buf) begin
        buf_n = nxt_buf;
        f_n   = '0;
`endif
      end else begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cur_buf     <= '0;
      f           <= '0;
      last        <= FW'(BUFFER_SIZE - 1);
      wfield      <= '0;
      bufp        <= '0;
      field_in    <= '0;
      field_write <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      byte_q      <= '0;
      ofield_q    <= '0;
`ifdef PATSEQ_CHAIN_EN
      first_buf   <= '0;
`endif
    end else begin
      state       <= state_n;
      cur_buf     <= buf_n;
      f           <= f_n;
      last        <= last_n;
      done_q      <= done_n;
      valid_q     <= rd_slot;
      ack_q       <= grant;
      err_q       <= grant && !in_range;
      field_write <= grant && in_range;
      bufp        <= grant ? core.wr_buf : buf_n;
`ifdef PATSEQ_CHAIN_EN
      first_buf   <= first_n;
`endif
      if (rd_slot) begin
        byte_q   <= field_byte;
        ofield_q <= f;
      end
      if (grant) begin
        wfield   <= core.wr_field;
        field_in <= core.wr_data;
      end
    end
  end

  onehot_dec #(.N(NO_BUFS)) u_sel (
    .idx (cur_buf),
    .en  (1'b1),
    .oh  (buffer_select)
  );

  onehot_dec #(.N(BUFFER_SIZE)) u_rdp (
    .idx (f),
    .en  (1'b1),
    .oh  (fieldp)
  );

  onehot_dec #(.N(BUFFER_SIZE)) u_wrp (
    .idx (wfield),
    .en  (field_write),
    .oh  (fieldwp)
  );

  assign core.wr_ack    = ack_q;
  assign core.wr_err    = err_q;
  assign core.out_valid = valid_q;
  assign core.out_byte  = byte_q;
  assign core.out_field = ofield_q;
  assign core.busy      = (state == RUN);
  assign core.done      = done_q;
endmodule
